// File: rtl/axi_wr_demux4.sv
// AXI4 write-channel demultiplexer: one master to four slaves.
// Address bits [17:16] pick the slave when bits [ADDR_W-1:18] are zero.
// Any other address is a decode miss. On a miss the W beats are sunk
// locally and the master gets a DECERR response.
// Only one transaction is in flight at a time. The beat count always
// follows awlen. A master WLAST that disagrees with that count is
// flagged on len_err for one cycle, but it does not end the burst.

module axi_wr_demux4 #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    // master write-address channel
    input  logic [ID_W-1:0]       m_awid,
    input  logic [ADDR_W-1:0]     m_awaddr,
    input  logic [3:0]            m_awlen,
    input  logic [2:0]            m_awsize,
    input  logic [1:0]            m_awburst,
    input  logic                  m_awvalid,
    output logic                  m_awready,

    // master write-data channel
    input  logic [DATA_W-1:0]     m_wdata,
    input  logic [DATA_W/8-1:0]   m_wstrb,
    input  logic                  m_wlast,
    input  logic                  m_wvalid,
    output logic                  m_wready,

    // master write-response channel
    output logic [ID_W-1:0]       m_bid,
    output logic [1:0]            m_bresp,
    output logic                  m_bvalid,
    input  logic                  m_bready,

    // slave write-address channels (shared payload)
    output logic [ID_W-1:0]       s_awid,
    output logic [ADDR_W-1:0]     s_awaddr,
    output logic [3:0]            s_awlen,
    output logic [2:0]            s_awsize,
    output logic [1:0]            s_awburst,
    output logic [3:0]            s_awvalid,
    input  logic [3:0]            s_awready,

    // slave write-data channels (shared payload)
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    output logic                  s_wlast,
    output logic [3:0]            s_wvalid,
    input  logic [3:0]            s_wready,

    // slave write-response channels
    input  logic [4*ID_W-1:0]     s_bid,
    input  logic [7:0]            s_bresp,
    input  logic [3:0]            s_bvalid,
    output logic [3:0]            s_bready,

    output logic                  len_err
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        RESP,
        ERR_DATA,
        ERR_RESP
    } state_t;

    localparam logic [1:0] RESP_DECERR = 2'b11;

    state_t            state;
    logic [ID_W-1:0]   awid_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [3:0]        awlen_q;
    logic [2:0]        awsize_q;
    logic [1:0]        awburst_q;
    logic [1:0]        sel_q;
    logic [3:0]        beat_q;

    logic              hit;
    logic              last_beat;
    logic [3:0]        sel_onehot;
    logic              w_hs;
    logic              b_hs;

    assign hit        = (m_awaddr[ADDR_W-1:18] == '0);
    assign last_beat  = (beat_q == awlen_q);
    assign sel_onehot = 4'b0001 << sel_q;
    assign w_hs       = m_wvalid && m_wready;
    assign b_hs       = m_bvalid && m_bready;

    // Transaction FSM: captures the AW payload, counts W beats and waits for the response.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every register here uses non-blocking assignment, so all of them
        // update together from the values they held before the clock edge.
        if (rst) begin
            state     <= IDLE;
            awid_q    <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            awburst_q <= '0;
            sel_q     <= '0;
            beat_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m_awvalid) begin
                        awid_q    <= m_awid;
                        awaddr_q  <= m_awaddr;
                        awlen_q   <= m_awlen;
                        awsize_q  <= m_awsize;
                        awburst_q <= m_awburst;
                        sel_q     <= m_awaddr[17:16];
                        beat_q    <= '0;
                        state     <= hit ? ADDR : ERR_DATA;
                    end
                end
                ADDR: begin
                    if (s_awready[sel_q]) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        beat_q <= beat_q + 4'd1;
                        if (last_beat) begin
                            state <= RESP;
                        end
                    end
                end
                ERR_DATA: begin
                    if (w_hs) begin
                        beat_q <= beat_q + 4'd1;
                        if (last_beat) begin
                            state <= ERR_RESP;
                        end
                    end
                end
                RESP, ERR_RESP: begin
                    if (b_hs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Channel routing: steer the handshakes to the selected slave, or sink them locally on a miss.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves one unassigned
        // and no latch is inferred.
        m_awready = 1'b0;
        s_awvalid = 4'b0000;
        m_wready  = 1'b0;
        s_wvalid  = 4'b0000;
        s_wlast   = 1'b0;
        m_bvalid  = 1'b0;
        m_bid     = awid_q;
        m_bresp   = 2'b00;
        s_bready  = 4'b0000;
        case (state)
            IDLE: begin
                m_awready = 1'b1;
            end
            ADDR: begin
                s_awvalid = sel_onehot;
            end
            DATA: begin
                s_wvalid = sel_onehot & {4{m_wvalid}};
                m_wready = s_wready[sel_q];
                s_wlast  = last_beat;
            end
            ERR_DATA: begin
                m_wready = 1'b1;
            end
            RESP: begin
                m_bvalid = s_bvalid[sel_q];
                m_bid    = s_bid[int'(sel_q) * ID_W +: ID_W];
                m_bresp  = s_bresp[int'(sel_q) * 2 +: 2];
                s_bready = sel_onehot & {4{m_bready}};
            end
            ERR_RESP: begin
                m_bvalid = 1'b1;
                m_bresp  = RESP_DECERR;
            end
            default: begin
                m_awready = 1'b0;
            end
        endcase
    end

    assign s_awid    = awid_q;
    assign s_awaddr  = awaddr_q;
    assign s_awlen   = awlen_q;
    assign s_awsize  = awsize_q;
    assign s_awburst = awburst_q;
    assign s_wdata   = m_wdata;
    assign s_wstrb   = m_wstrb;
    assign len_err   = w_hs && (m_wlast != last_beat);

endmodule

// File: tb/tb_axi_wr_demux4.sv
// Directed bench for axi_wr_demux4.
// Inputs change on the falling edge. Outputs are sampled 1 ns later,
// well away from the rising edge.

module tb_axi_wr_demux4;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [ID_W-1:0]     m_awid;
    logic [ADDR_W-1:0]   m_awaddr;
    logic [3:0]          m_awlen;
    logic [2:0]          m_awsize;
    logic [1:0]          m_awburst;
    logic                m_awvalid;
    logic                m_awready;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic                m_wlast;
    logic                m_wvalid;
    logic                m_wready;
    logic [ID_W-1:0]     m_bid;
    logic [1:0]          m_bresp;
    logic                m_bvalid;
    logic                m_bready;
    logic [ID_W-1:0]     s_awid;
    logic [ADDR_W-1:0]   s_awaddr;
    logic [3:0]          s_awlen;
    logic [2:0]          s_awsize;
    logic [1:0]          s_awburst;
    logic [3:0]          s_awvalid;
    logic [3:0]          s_awready;
    logic [DATA_W-1:0]   s_wdata;
    logic [DATA_W/8-1:0] s_wstrb;
    logic                s_wlast;
    logic [3:0]          s_wvalid;
    logic [3:0]          s_wready;
    logic [4*ID_W-1:0]   s_bid;
    logic [7:0]          s_bresp;
    logic [3:0]          s_bvalid;
    logic [3:0]          s_bready;
    logic                len_err;

    int errors = 0;
    int checks = 0;

    axi_wr_demux4 #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .len_err(len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clear_inputs();
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_wlast   = 1'b0;
        m_bready  = 1'b0;
        s_awready = 4'b0000;
        s_wready  = 4'b0000;
        s_bvalid  = 4'b0000;
    endtask

    task automatic drive_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
        m_awvalid = 1'b1;
        m_awid    = id;
        m_awaddr  = addr;
        m_awlen   = len;
        m_awsize  = 3'd2;
        m_awburst = 2'b01;
    endtask

    // Watchdog: the directed sequence is fixed-length, so this only fires if something hangs.
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0;
        m_wdata = '0; m_wstrb = '0;
        s_bid = 16'h3759;  // slice0=9 slice1=5 slice2=7 slice3=3
        s_bresp = 8'b11_00_10_01;
        clear_inputs();

        // ---------------- reset state
        @(negedge clk); #1;
        check("rst_awready", m_awready, 1);
        check("rst_awvalid", s_awvalid, 0);
        check("rst_wvalid",  s_wvalid, 0);
        check("rst_wready",  m_wready, 0);
        check("rst_bvalid",  m_bvalid, 0);
        check("rst_bready",  s_bready, 0);
        check("rst_len_err", len_err, 0);
        check("rst_awaddr",  s_awaddr, 0);

        // ---------------- slave 2, awlen=3
        @(negedge clk); rst = 1'b0; drive_aw(4'h5, 32'h0002_0000, 4'd3); #1;
        check("a_awready", m_awready, 1);
        @(negedge clk); m_awvalid = 1'b0; s_awready = 4'b0100; #1;
        check("a_s_awvalid", s_awvalid, 4'b0100);
        check("a_s_awaddr", s_awaddr, 32'h0002_0000);
        check("a_s_awid", s_awid, 4'h5);
        check("a_s_awlen", s_awlen, 3);
        check("a_awready_busy", m_awready, 0);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            s_awready = 4'b0000; m_wvalid = 1'b1; m_wdata = 32'(32'hA0 + b);
            m_wstrb = 4'hF; m_wlast = (b == 3); s_wready = 4'b0100; #1;
            check("a_s_wvalid", s_wvalid, 4'b0100);
            check("a_m_wready", m_wready, 1);
            check("a_s_wdata", s_wdata, 32'(32'hA0 + b));
            check("a_s_wlast", s_wlast, (b == 3));
            check("a_len_err", len_err, 0);
        end
        @(negedge clk);
        m_wvalid = 1'b0; m_wlast = 1'b0; s_wready = 4'b0000;
        s_bvalid = 4'b0100; m_bready = 1'b1; #1;
        check("a_m_bvalid", m_bvalid, 1);
        check("a_m_bid", m_bid, 4'h7);
        check("a_m_bresp", m_bresp, 2'b00);
        check("a_s_bready", s_bready, 4'b0100);
        check("a_wready_resp", m_wready, 0);
        @(negedge clk); clear_inputs(); #1;
        check("a_idle", m_awready, 1);
        check("a_bvalid_idle", m_bvalid, 0);

        // ---------------- decode miss, awlen=1
        @(negedge clk); drive_aw(4'hC, 32'h0004_0000, 4'd1); #1;
        check("b_awready", m_awready, 1);
        @(negedge clk);
        m_awvalid = 1'b0; m_wvalid = 1'b1; m_wlast = 1'b0;
        s_wready = 4'hF; s_awready = 4'hF; #1;
        check("b_no_awvalid", s_awvalid, 0);
        check("b_m_wready", m_wready, 1);
        check("b_no_wvalid", s_wvalid, 0);
        check("b_len_err0", len_err, 0);
        @(negedge clk); m_wlast = 1'b1; #1;
        check("b_m_wready1", m_wready, 1);
        check("b_no_wvalid1", s_wvalid, 0);
        check("b_len_err1", len_err, 0);
        @(negedge clk); clear_inputs(); s_bvalid = 4'hF; #1;
        check("b_m_bvalid", m_bvalid, 1);
        check("b_m_bresp", m_bresp, 2'b11);
        check("b_m_bid", m_bid, 4'hC);
        check("b_no_bready", s_bready, 0);
        check("b_wready_resp", m_wready, 0);
        @(negedge clk); m_bready = 1'b1; s_bvalid = 4'h0; #1;
        check("b_bvalid_hold", m_bvalid, 1);
        @(negedge clk); clear_inputs(); #1;
        check("b_idle", m_awready, 1);

        // ---------------- slave 0, awlen=2, early WLAST on beat 1
        @(negedge clk); drive_aw(4'h1, 32'h0000_0010, 4'd2); #1;
        check("c_awready", m_awready, 1);
        @(negedge clk); m_awvalid = 1'b0; s_awready = 4'b0001; #1;
        check("c_s_awvalid", s_awvalid, 4'b0001);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            s_awready = 4'b0000; m_wvalid = 1'b1; m_wlast = (b >= 1); s_wready = 4'b0001; #1;
            check("c_m_wready", m_wready, 1);
            check("c_s_wvalid", s_wvalid, 4'b0001);
            check("c_len_err", len_err, (b == 1));
            check("c_s_wlast", s_wlast, (b == 2));
        end
        @(negedge clk);
        m_wvalid = 1'b0; m_wlast = 1'b0; s_wready = 4'b0000;
        s_bvalid = 4'b0001; m_bready = 1'b1; #1;
        check("c_m_bvalid", m_bvalid, 1);
        check("c_m_bid", m_bid, 4'h9);
        check("c_m_bresp", m_bresp, 2'b01);
        @(negedge clk); clear_inputs(); #1;
        check("c_idle", m_awready, 1);

        // ---------------- slave 1, awlen=0, stalled AW and B
        @(negedge clk); drive_aw(4'h3, 32'h0001_0000, 4'd0); #1;
        check("d_awready", m_awready, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); m_awvalid = 1'b0; m_awaddr = 32'hFFFF_FFFF; s_awready = 4'b0000; #1;
            check("d_awvalid_hold", s_awvalid, 4'b0010);
            check("d_awaddr_hold", s_awaddr, 32'h0001_0000);
            check("d_awid_hold", s_awid, 4'h3);
        end
        @(negedge clk); s_awready = 4'b0010; #1;
        check("d_awvalid", s_awvalid, 4'b0010);
        @(negedge clk); s_awready = 4'b0000; m_wvalid = 1'b1; m_wlast = 1'b1; s_wready = 4'b0010; #1;
        check("d_s_wlast", s_wlast, 1);
        check("d_s_wvalid", s_wvalid, 4'b0010);
        check("d_len_err", len_err, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            m_wvalid = 1'b0; m_wlast = 1'b0; s_wready = 4'b0000;
            s_bvalid = 4'b0010; m_bready = 1'b0; #1;
            check("d_bvalid_hold", m_bvalid, 1);
            check("d_bready_low", s_bready, 0);
            check("d_m_bid", m_bid, 4'h5);
        end
        @(negedge clk); m_bready = 1'b1; #1;
        check("d_s_bready", s_bready, 4'b0010);
        @(negedge clk); clear_inputs(); #1;
        check("d_idle", m_awready, 1);

        // ---------------- reset mid-burst
        @(negedge clk); drive_aw(4'h2, 32'h0002_0000, 4'd3); #1;
        check("e_awready", m_awready, 1);
        @(negedge clk); m_awvalid = 1'b0; s_awready = 4'b0100; #1;
        check("e_s_awvalid", s_awvalid, 4'b0100);
        @(negedge clk); s_awready = 4'b0000; m_wvalid = 1'b1; s_wready = 4'b0100; #1;
        check("e_beat0", s_wvalid, 4'b0100);
        @(negedge clk); #1;
        check("e_beat1", m_wready, 1);
        rst = 1'b1; #1;
        check("e_rst_wvalid", s_wvalid, 0);
        check("e_rst_wready", m_wready, 0);
        check("e_rst_awready", m_awready, 1);
        check("e_rst_awaddr", s_awaddr, 0);
        @(negedge clk); rst = 1'b0; clear_inputs(); #1;
        check("e_idle", m_awready, 1);
        check("e_idle_wvalid", s_wvalid, 0);

        // ---------------- back-to-back: slave 0 then slave 3
        @(negedge clk); drive_aw(4'h4, 32'h0000_0000, 4'd0); #1;
        check("f_awready1", m_awready, 1);
        @(negedge clk); m_awid = 4'h6; m_awaddr = 32'h0003_0000; s_awready = 4'b0001; #1;
        check("f_busy_addr", m_awready, 0);
        check("f_s_awvalid1", s_awvalid, 4'b0001);
        check("f_s_awaddr1", s_awaddr, 32'h0000_0000);
        @(negedge clk); s_awready = 4'b0000; m_wvalid = 1'b1; m_wlast = 1'b1; s_wready = 4'hF; #1;
        check("f_s_wvalid1", s_wvalid, 4'b0001);
        check("f_busy_data", m_awready, 0);
        @(negedge clk); m_wvalid = 1'b0; s_wready = 4'b0000; s_bvalid = 4'hF; m_bready = 1'b1; #1;
        check("f_s_bready1", s_bready, 4'b0001);
        check("f_busy_resp", m_awready, 0);
        check("f_m_bid1", m_bid, 4'h9);
        @(negedge clk); s_bvalid = 4'b0000; m_bready = 1'b0; #1;
        check("f_idle_gap", m_awready, 1);
        check("f_no_awvalid", s_awvalid, 0);
        @(negedge clk); m_awvalid = 1'b0; #1;
        check("f_s_awvalid2", s_awvalid, 4'b1000);
        check("f_s_awid2", s_awid, 4'h6);
        check("f_s_awaddr2", s_awaddr, 32'h0003_0000);
        @(negedge clk); s_awready = 4'b1000; #1;
        @(negedge clk); s_awready = 4'b0000; m_wvalid = 1'b1; m_wlast = 1'b1; s_wready = 4'b1000; #1;
        check("f_s_wvalid2", s_wvalid, 4'b1000);
        check("f_s_wlast2", s_wlast, 1);
        @(negedge clk); clear_inputs(); s_bvalid = 4'b1000; m_bready = 1'b1; #1;
        check("f_m_bid2", m_bid, 4'h3);
        check("f_m_bresp2", m_bresp, 2'b11);
        check("f_s_bready2", s_bready, 4'b1000);
        @(negedge clk); clear_inputs(); #1;
        check("f_idle", m_awready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
